// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared encodings for the main-control decoder of the multi-cycle
//   MIPS-subset CPU: opcode values, control-word bit positions, the
//   REGDST / ALUB field encodings, the 13-bit control word type and a
//   helper that packs individual fields into a control word.
package cpu_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Control word layout
    localparam int CTRL_W    = 13;
    localparam int B_JUMP    = 0;
    localparam int B_BRANCH  = 1;
    localparam int B_JSRC    = 2;
    localparam int B_MEMWR   = 3;
    localparam int B_MEMRD   = 4;
    localparam int B_REGWR   = 5;
    localparam int B_MEM2REG = 6;
    localparam int B_REGDST  = 7;   // 2-bit field [8:7]
    localparam int B_ALUB    = 9;   // 2-bit field [10:9]
    localparam int B_ALUA    = 11;
    localparam int B_RTYPE   = 12;

    // REGDST field: destination register select (2'b11 is reserved)
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;   // $31, link register

    // ALUB field: second ALU operand select
    localparam logic [1:0] ALUB_RB      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // Packs named fields into a control word so the decode table reads
    // by meaning rather than by hex constant.
    function automatic ctrl_word_t make_word(
        input logic       rtype,
        input logic       alua,
        input logic [1:0] alub,
        input logic [1:0] regdst,
        input logic       mem2reg,
        input logic       regwr,
        input logic       memrd,
        input logic       memwr,
        input logic       jsrc,
        input logic       branch,
        input logic       jump
    );
        ctrl_word_t w;
        w                       = '0;
        w[B_RTYPE]              = rtype;
        w[B_ALUA]               = alua;
        w[B_ALUB+1:B_ALUB]      = alub;
        w[B_REGDST+1:B_REGDST]  = regdst;
        w[B_MEM2REG]            = mem2reg;
        w[B_REGWR]              = regwr;
        w[B_MEMRD]              = memrd;
        w[B_MEMWR]              = memwr;
        w[B_JSRC]               = jsrc;
        w[B_BRANCH]             = branch;
        w[B_JUMP]               = jump;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder
//   Main-control decoder. The opcode latched in IF is decoded into a
//   13-bit control word that is registered and valid from the next cycle.
//   Only the opcode is decoded; R-type ALU ops come from funct in the
//   datapath.
// Ports
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous active-high reset, clears signal
//   op      in   6   instruction opcode instr[31:26]
//   signal  out  13  registered control word
module ctrl_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        op,
    output logic [CTRL_W-1:0] signal
);

    ctrl_word_t decoded;

    // Field order: rtype, alua, alub, regdst, mem2reg, regwr, memrd,
    //              memwr, jsrc, branch, jump
    always_comb begin
        decoded = '0;
        case (op)
            OP_RTYPE:
                decoded = make_word(1'b1, 1'b1, ALUB_RB, REGDST_RD,
                                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            OP_J:
                decoded = make_word(1'b0, 1'b0, ALUB_RB, REGDST_RT,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            // jal writes PC+4 into $31: ALU computes PC + 4.
            OP_JAL:
                decoded = make_word(1'b0, 1'b0, ALUB_FOUR, REGDST_RA,
                                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            // Branch target add uses PC + (sext imm << 2); the RA/RB
            // comparison is done in the datapath.
            OP_BEQ, OP_BNE:
                decoded = make_word(1'b0, 1'b0, ALUB_IMM_SH2, REGDST_RT,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                decoded = make_word(1'b0, 1'b1, ALUB_IMM, REGDST_RT,
                                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            OP_LW:
                decoded = make_word(1'b0, 1'b1, ALUB_IMM, REGDST_RT,
                                    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            OP_SW:
                decoded = make_word(1'b0, 1'b1, ALUB_IMM, REGDST_RT,
                                    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            // Unlisted (and X/Z in simulation) opcodes become a NOP.
            default:
                decoded = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) signal <= '0;
        else     signal <= decoded;
    end

endmodule

// File: tb/tb_ctrl_decoder.sv
// tb_ctrl_decoder
//   Directed bench for ctrl_decoder: reset behaviour, full opcode sweep,
//   back-to-back decode, mid-stream reset and control-word invariants
//   over random opcodes. Expected words are hand-written hex constants.
module tb_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op  = 6'h00;
    logic [12:0] signal;

    int errors = 0;
    int checks = 0;

    ctrl_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .signal (signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 13'h%04h expected 13'h%04h", tag, got, exp);
        end
    endtask

    // Hand-written decode table.
    function automatic logic [12:0] expect_word(input logic [5:0] o);
        case (o)
            6'h00:                                    return 13'h18A0;
            6'h02:                                    return 13'h0001;
            6'h03:                                    return 13'h0321;
            6'h04, 6'h05:                             return 13'h0602;
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return 13'h0C20;
            6'h23:                                    return 13'h0C70;
            6'h2B:                                    return 13'h0C08;
            default:                                  return 13'h0000;
        endcase
    endfunction

    // Apply op at negedge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [5:0] o);
        @(negedge clk);
        op = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0]  r;
        logic [12:0] s;

        // Async reset before any clock edge
        op = 6'h23;
        #1 rst = 1'b1;
        #1;
        chk("reset_async", signal, 13'h0000);
        @(posedge clk);
        #1;
        chk("reset_held", signal, 13'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release_lw", signal, 13'h0C70);

        // Full opcode sweep
        for (int i = 0; i < 64; i++) begin
            step(6'(i));
            chk($sformatf("sweep_op%02h", i), signal, expect_word(6'(i)));
        end

        // Back-to-back R-type then sw
        step(6'h00);
        chk("b2b_rtype", signal, 13'h18A0);
        step(6'h2B);
        chk("b2b_sw", signal, 13'h0C08);

        // Mid-stream reset while jal is decoding
        step(6'h03);
        chk("mid_jal", signal, 13'h0321);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_drop", signal, 13'h0000);
        @(posedge clk);
        #1;
        chk("mid_rst_held", signal, 13'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_recover", signal, 13'h0321);

        // Random ops: table match plus invariants
        for (int i = 0; i < 200; i++) begin
            r = 6'($urandom_range(0, 63));
            step(r);
            s = signal;
            chk($sformatf("rand_op%02h", r), s, expect_word(r));
            chk("inv_rd_wr", {12'd0, s[3] & s[4]}, 13'd0);
            chk("inv_jmp_br", {12'd0, s[0] & s[1]}, 13'd0);
            chk("inv_m2r", {12'd0, s[6] & ~(s[5] & s[4])}, 13'd0);
            chk("inv_regdst", {12'd0, s[8] & s[7]}, 13'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
